conv_window_ctrl: RTL

Controller that sequences the two-read-port register buffer of the convolution engine as a circular sample window.
- Accepts an input sample stream and drives the buffer write strobe and write address.
- After each new sample, once the window is full, walks the KernelSize most-recent samples two per cycle.
- Drives both buffer read addresses plus tap indices, so the downstream MAC pair can fetch data and coefficients.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_addr_gen.sv | 22 ++
 rtl/conv_window_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window controller.
package conv_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      ACCEPT = 2'd1,
      READ   = 2'd2
   } state_t;

   // Number of read pairs needed to cover k taps.
   function automatic int unsigned np_calc(input int unsigned k);
      return (k + 1) / 2;
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Maps newest-sample address and pair index to the two buffer read addresses and tap indices.
module conv_addr_gen #(
   parameter int unsigned BufferWidth = 2
) (
   input  logic [BufferWidth-1:0] newest,
   input  logic [BufferWidth-1:0] pair,
   output logic [BufferWidth-1:0] raddr1,
   output logic [BufferWidth-1:0] raddr2,
   output logic [BufferWidth-1:0] tap1,
   output logic [BufferWidth-1:0] tap2
);

   logic [BufferWidth-1:0] two_p;

   // Modular arithmetic wraps naturally at the buffer depth.
   assign two_p  = BufferWidth'({pair, 1'b0});
   assign raddr1 = newest - two_p;
   assign raddr2 = newest - two_p - BufferWidth'(1);
   assign tap1   = two_p;
   assign tap2   = two_p + BufferWidth'(1);

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences a two-read-port buffer as a circular sample window, walking the
// newest KernelSize samples two per cycle after every accepted sample.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned DataWidth   = 8,
   parameter int unsigned BufferSize  = 4,
   parameter int unsigned BufferWidth = 2,
   parameter int unsigned KernelSize  = 4
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   buf_en,
   output logic [BufferWidth-1:0] buf_waddr,
   output logic [BufferWidth-1:0] buf_raddr1,
   output logic [BufferWidth-1:0] buf_raddr2,
   output logic                   rd_valid,
   output logic                   rd_valid2,
   input  logic                   rd_ready,
   output logic [BufferWidth-1:0] tap1,
   output logic [BufferWidth-1:0] tap2,
   output logic                   rd_first,
   output logic                   rd_last
);

   localparam int unsigned NP   = np_calc(KernelSize);
   localparam int unsigned FW   = $clog2(KernelSize + 1);
   localparam bit          KODD = (KernelSize % 2) == 1;

   // Elaboration-time parameter sanity checks.
   if (BufferSize != (1 << BufferWidth)) begin : g_bad_depth
      $error("BufferSize must equal 2**BufferWidth");
   end
   if (KernelSize < 2 || KernelSize > BufferSize) begin : g_bad_kernel
      $error("KernelSize must lie in 2..BufferSize");
   end
   if (DataWidth < 1) begin : g_bad_data
      $error("DataWidth must be at least 1");
   end

   state_t                 state;
   logic [BufferWidth-1:0] wr_ptr;
   logic [FW-1:0]          fill_cnt;
   logic [BufferWidth-1:0] p;

   logic                   reading;
   logic                   last_pair;
   logic [BufferWidth-1:0] newest;
   logic [BufferWidth-1:0] ag_raddr1, ag_raddr2, ag_tap1, ag_tap2;

   assign reading   = (state == READ);
   assign last_pair = (p == BufferWidth'(NP - 1));
   assign newest    = wr_ptr - BufferWidth'(1);

   // aclr gates in_ready directly so the stream sees no acceptance during reset.
   assign in_ready  = !aclr && !flush && !reading;
   assign buf_en    = in_valid && in_ready;
   assign buf_waddr = wr_ptr;

   conv_addr_gen #(
      .BufferWidth(BufferWidth)
   ) u_addr_gen (
      .newest (newest),
      .pair   (p),
      .raddr1 (ag_raddr1),
      .raddr2 (ag_raddr2),
      .tap1   (ag_tap1),
      .tap2   (ag_tap2)
   );

   assign rd_valid   = reading;
   assign rd_valid2  = reading && !(KODD && last_pair);
   assign rd_first   = reading && (p == '0);
   assign rd_last    = reading && last_pair;
   assign buf_raddr1 = reading ? ag_raddr1 : '0;
   assign buf_raddr2 = reading ? ag_raddr2 : '0;
   assign tap1       = reading ? ag_tap1   : '0;
   assign tap2       = reading ? ag_tap2   : '0;

   // Window FSM; flush abandons the window but keeps wr_ptr and buffer contents.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state    <= FILL;
         wr_ptr   <= '0;
         fill_cnt <= '0;
         p        <= '0;
      end else if (flush) begin
         state    <= FILL;
         fill_cnt <= '0;
         p        <= '0;
      end else begin
         if (buf_en) begin
            wr_ptr <= wr_ptr + BufferWidth'(1);
            if (fill_cnt != FW'(KernelSize))
               fill_cnt <= fill_cnt + FW'(1);
         end
         case (state)
            FILL: begin
               if (buf_en && fill_cnt == FW'(KernelSize - 1)) begin
                  state <= READ;
                  p     <= '0;
               end
            end
            ACCEPT: begin
               if (buf_en) begin
                  state <= READ;
                  p     <= '0;
               end
            end
            READ: begin
               if (rd_ready) begin
                  if (last_pair) begin
                     state <= ACCEPT;
                     p     <= '0;
                  end else begin
                     p <= p + BufferWidth'(1);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
